mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator-side load/store unit between the CPU MEM stage and the banked data memory.
//  Accepts one load/store request, drives the data-memory port (MEM_ADDR/MEM_READ/MEM_WRITE/
//  MEM_DATA_TYPE/MEM_DATA_IN) and returns a one-cycle response to the pipeline.
//  Aligned requests issue a single beat. Misaligned requests are split into UBYTE beats and
//  reassembled/extended here.
// PARAMETERS
//  BITS        32  data width (from common_params)
//  ADDRW       32  byte-address width (from common_params)
//  RD_LATENCY  1   cycles from MEM_READ/MEM_ADDR valid to MEM_DATA_OUT valid (0 = combinational)
// PORTS
//  clk            in   1      global clock
//  rst            in   1      synchronous, active-high reset
//  req_valid      in   1      pipeline request strobe
//  req_ready      out  1      high only in IDLE; a request is accepted when req_valid & req_ready
//  req_write      in   1      1 = store, 0 = load
//  req_type       in   mem_data_t  BYTE/HALFWORD/WORD/UBYTE/UHALFWORD/LWCP
//  req_addr       in   ADDRW  byte address
//  req_wdata      in   BITS   store data, right-justified
//  resp_valid     out  1      one-cycle completion pulse; no backpressure
//  resp_rdata     out  BITS   load result, extended per req_type; 0 for stores
//  resp_err       out  1      misaligned trap (only with MAU_MISALIGN_TRAP_EN)
//  MEM_ADDR       out  ADDRW  memory byte address
//  MEM_DATA_IN    out  BITS   store data, right-justified; memory shifts it into lanes
//  MEM_WRITE      out  1      write strobe, one cycle per store beat
//  MEM_READ       out  1      read enable, held for RD_LATENCY+1 cycles per load beat
//  MEM_DATA_TYPE  out  mem_data_t  access type of the current beat
//  MEM_DATA_OUT   in   BITS   shifted and extended read data from memory
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: req_ready=0 during rst, then 1 in IDLE. resp_valid=0, resp_rdata=0,
//    resp_err=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_DATA_IN=0, MEM_DATA_TYPE=WORD.
//  - Misaligned conditions:
//    * (U)HALFWORD with addr[0]=1.
//    * WORD/LWCP with addr[1:0]!=0.
//    * BYTE/UBYTE are never misaligned.
//  - FSM states: IDLE -> ISSUE -> (WAIT)* -> [next beat: ISSUE] -> RESP -> IDLE.
//    * IDLE: on accept, latch the request and compute beat count N: 1 if aligned,
//      2 for a split halfword, 4 for a split word. Go to ISSUE.
//    * ISSUE:
//      - Drive beat k: MEM_ADDR = addr+k (ADDRW wrap-around allowed).
//      - MEM_DATA_TYPE = req_type if aligned, else UBYTE.
//      - MEM_DATA_IN = wdata if aligned, else wdata byte k in [7:0].
//      - Store beat: MEM_WRITE for 1 cycle, then next beat or RESP.
//      - Load beat: MEM_READ asserted; go to WAIT.
//    * WAIT: hold address and MEM_READ for RD_LATENCY further cycles. Sample MEM_DATA_OUT in
//      the last cycle. For a split access, place [7:0] into byte lane k of the assembly register.
//    * RESP: resp_valid=1 for one cycle.
//      - Aligned load: resp_rdata = sampled data.
//      - Split load: assembled value, sign-extended from bit 15 for HALFWORD, zero-extended
//        for UHALFWORD; words pass through.
//      - Store: resp_rdata = 0.
//      - Return to IDLE; req_ready rises in the following cycle.
//  - Latency from the accept cycle T:
//    * Aligned store: resp at T+2.
//    * Aligned load: resp at T+3+RD_LATENCY-1.
//    * Split access: each load beat takes RD_LATENCY+1 cycles; each store beat takes 1 cycle.
//  - MEM_READ and MEM_WRITE are never high together. Both are low in IDLE and RESP.
//  - req_valid while not in IDLE is ignored (req_ready=0). There is no queueing.
//  - rst mid-operation: next state is IDLE, strobes are deasserted, assembly register is cleared.
//    No response is produced for the aborted request. Stores already written are not rolled back.
// CONFIGURATION
//  - MAU_MISALIGN_TRAP_EN defined:
//    * A misaligned request issues no memory beat and goes IDLE -> RESP directly.
//    * RESP drives resp_valid=1, resp_err=1, resp_rdata=0.
//    * Aligned requests behave as without the macro.
//  - Undefined: misaligned requests are split as described above; resp_err is tied to 0.
// STRUCTURE
//  - common_params gains:
//    * mau_state_t enum {IDLE, ISSUE, WAIT, RESP}.
//    * Function is_misaligned(mem_data_t, addr[1:0]).
//    * Localparam MAX_BEATS = BYTES_PER_WORD.
//    * mem_data_t and shift_t are reused unchanged.
//  - Sub-module mau_assembler: byte-lane insert, plus final sign/zero extension by req_type.
//  - The FSM, beat counter and RD_LATENCY wait counter stay in mau_access_unit.
// TESTING
//  - Aligned SW addr 0x100, data 0xDEADBEEF:
//    * MEM_WRITE 1 cycle, MEM_ADDR=0x100, MEM_DATA_TYPE=WORD.
//    * resp_valid at T+2, resp_rdata=0.
//  - Aligned LW 0x100 after that store (RD_LATENCY=1):
//    * MEM_READ 2 cycles, resp_rdata=0xDEADBEEF at T+3.
//  - Split LH at 0x101, memory bytes 0x101=0x80, 0x102=0xFF:
//    * 2 UBYTE beats to 0x101 and 0x102.
//    * resp_rdata=0xFFFFFF80 for LH; 0x0000FF80 for LHU.
//  - Split SW 0x12345678 at 0x203:
//    * 4 UBYTE writes to 0x203..0x206 with data 0x78, 0x56, 0x34, 0x12.
//    * Aligned LW 0x204 then returns 0x00123456 (upper byte from the prior 0x207 contents = 0).
//  - rst asserted during beat 2 of a split load:
//    * MEM_READ=0 next cycle, no resp_valid, req_ready=1 once rst deasserts.
//    * A new aligned LB at 0x100 returns 0xFFFFFFEF.
//  - MAU_MISALIGN_TRAP_EN, LW at 0x102:
//    * No MEM_READ/MEM_WRITE pulse.
//    * resp_valid=1, resp_err=1, resp_rdata=0 at T+1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types, sizes and helpers for the load/store unit.
// Holds the access-type enum, the FSM state enum and the misalignment check.
package mem_access_unit_pkg;

  localparam int BITS           = 32;
  localparam int ADDRW          = 32;
  localparam int BYTES_PER_WORD = BITS / 8;
  localparam int MAX_BEATS      = BYTES_PER_WORD;
  localparam int BEATW          = $clog2(MAX_BEATS);

  typedef enum logic [2:0] {
    BYTE,
    HALFWORD,
    WORD,
    UBYTE,
    UHALFWORD,
    LWCP
  } mem_data_t;

  typedef logic [BEATW-1:0] shift_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mau_state_t;

  function automatic logic is_misaligned(mem_data_t t, logic [1:0] a);
    unique case (1'b1)
      (t == HALFWORD || t == UHALFWORD): is_misaligned = a[0];
      (t == WORD || t == LWCP):          is_misaligned = (a != 2'b00);
      default:                           is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_assembler.sv
// Byte-lane insert for split loads and the final sign/zero extension.
// Purely combinational so the result can be registered on the last beat.
module mau_assembler
  import mem_access_unit_pkg::*;
(
  input  logic [BITS-1:0] asm_q,
  input  logic [BITS-1:0] din,
  input  shift_t          lane,
  input  logic            split,
  input  mem_data_t       rtype,
  output logic [BITS-1:0] asm_d,
  output logic [BITS-1:0] result
);

  always_comb begin
    asm_d = asm_q;
    asm_d[{lane, 3'b000} +: 8] = din[7:0];
  end

  always_comb begin
    result = asm_d;
    if (!split) begin
      result = din;
    end else begin
      unique case (rtype)
        HALFWORD:  result = {{(BITS-16){asm_d[15]}}, asm_d[15:0]};
        UHALFWORD: result = {{(BITS-16){1'b0}}, asm_d[15:0]};
        default:   result = asm_d;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: splits misaligned accesses into UBYTE beats and reassembles.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned requests instead of splitting.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  mem_data_t        req_type,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [BITS-1:0]  req_wdata,
  output logic             resp_valid,
  output logic [BITS-1:0]  resp_rdata,
  output logic             resp_err,
  output logic [ADDRW-1:0] MEM_ADDR,
  output logic [BITS-1:0]  MEM_DATA_IN,
  output logic             MEM_WRITE,
  output logic             MEM_READ,
  output mem_data_t        MEM_DATA_TYPE,
  input  logic [BITS-1:0]  MEM_DATA_OUT
);

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam bit         ZERO_LAT  = (RD_LATENCY == 0);
  localparam logic [7:0] WCNT_INIT = 8'(RD_LATENCY - 1);

  mau_state_t       state;
  logic             rq_write;
  mem_data_t        rq_type;
  logic [ADDRW-1:0] rq_addr;
  logic [BITS-1:0]  rq_wdata;
  logic             split;
  shift_t           beat;
  shift_t           last;
  logic [7:0]       wcnt;
  logic [BITS-1:0]  asm_q;

  logic             acc_mis;
  shift_t           acc_last;
  shift_t           nbeat;
  logic [ADDRW-1:0] nxt_addr;
  logic [BITS-1:0]  nxt_data;
  logic             beat_done;
  logic [BITS-1:0]  asm_d;
  logic [BITS-1:0]  result;

  always_comb begin
    acc_mis  = is_misaligned(req_type, req_addr[1:0]);
    acc_last = '0;
    if (acc_mis) begin
      acc_last = (req_type == HALFWORD || req_type == UHALFWORD)
               ? shift_t'(1) : shift_t'(MAX_BEATS - 1);
    end
    nbeat    = beat + 1'b1;
    nxt_addr = rq_addr + ADDRW'(nbeat);
    nxt_data = BITS'(rq_wdata[{nbeat, 3'b000} +: 8]);
  end

  // A store beat always finishes in ISSUE; a load beat finishes on its
  // last WAIT cycle, or in ISSUE when memory reads combinationally.
  assign beat_done = (state == ISSUE && (rq_write || ZERO_LAT))
                  || (state == WAIT && wcnt == '0);

  mau_assembler u_asm (
    .asm_q  (asm_q),
    .din    (MEM_DATA_OUT),
    .lane   (beat),
    .split  (split),
    .rtype  (rq_type),
    .asm_d  (asm_d),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_DATA_IN   <= '0;
      MEM_WRITE     <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_DATA_TYPE <= WORD;
      rq_write      <= 1'b0;
      rq_type       <= WORD;
      rq_addr       <= '0;
      rq_wdata      <= '0;
      split         <= 1'b0;
      beat          <= '0;
      last          <= '0;
      wcnt          <= '0;
      asm_q         <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rq_write  <= req_write;
            rq_type   <= req_type;
            rq_addr   <= req_addr;
            rq_wdata  <= req_wdata;
            split     <= acc_mis;
            last      <= acc_last;
            beat      <= '0;
            asm_q     <= '0;
            if (TRAP_EN && acc_mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state         <= ISSUE;
              MEM_ADDR      <= req_addr;
              MEM_DATA_TYPE <= acc_mis ? UBYTE : req_type;
              MEM_DATA_IN   <= acc_mis ? BITS'(req_wdata[7:0])
                                       : req_wdata;
              MEM_WRITE     <= req_write;
              MEM_READ      <= !req_write;
            end
          end
        end
        ISSUE: begin
          if (!beat_done) begin
            state <= WAIT;
            wcnt  <= WCNT_INIT;
          end
        end
        WAIT: begin
          if (!beat_done) wcnt <= wcnt - 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (beat_done) begin
        if (!rq_write) asm_q <= asm_d;
        if (beat == last) begin
          state      <= RESP;
          MEM_READ   <= 1'b0;
          MEM_WRITE  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= rq_write ? '0 : result;
        end else begin
          state       <= ISSUE;
          beat        <= nbeat;
          MEM_ADDR    <= nxt_addr;
          MEM_DATA_IN <= nxt_data;
          MEM_WRITE   <= rq_write;
          MEM_READ    <= !rq_write;
        end
      end
    end
  end

endmodule
